// File: rtl/rf_multiport_sb_pkg.sv
// rf_pkg: shared defaults and types for the multi-port register file with scoreboard.
package rf_pkg;
   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NUM_RD = 2;
   localparam int RF_NUM_WR = 2;
   localparam int RF_ZERO_REG = 0;
   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rf_multiport_sb_if.sv
// rf_multiport_sb_if: write, read, issue and debug signals of the register file.
interface rf_multiport_sb_if import rf_pkg::*; #(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD,
   parameter int NUM_WR = RF_NUM_WR
);
   logic [NUM_WR-1:0]        we;
   logic [NUM_WR*ADDR_W-1:0] waddr;
   logic [NUM_WR*DATA_W-1:0] wdata;
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rbusy;
   logic                     issue_valid;
   logic [ADDR_W-1:0]        issue_rd;
   logic [ADDR_W-1:0]        dbg_sel;
   logic [DATA_W-1:0]        dbg_data;
   modport master (output we, waddr, wdata, raddr, issue_valid, issue_rd, dbg_sel,
                   input rdata, rbusy, dbg_data);
   modport slave (input we, waddr, wdata, raddr, issue_valid, issue_rd, dbg_sel,
                  output rdata, rbusy, dbg_data);
endinterface

// File: rtl/rf_multiport_sb_wr_select.sv
// rf_wr_select: picks the enabled write port matching addr; the highest port index wins.
module rf_wr_select #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_WR = 2
) (
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0]        addr,
   output logic                     hit,
   output logic [DATA_W-1:0]        data
);
   always_comb begin
      hit = 1'b0;
      data = '0;
      for (int k = 0; k < NUM_WR; k++)
         if (we[k] && waddr[k*ADDR_W +: ADDR_W] == addr) begin
            hit = 1'b1;
            data = wdata[k*DATA_W +: DATA_W];
         end
   end
endmodule

// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: multi-port register file with per-entry busy scoreboard and debug port.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module rf_multiport_sb import rf_pkg::*; #(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD,
   parameter int NUM_WR = RF_NUM_WR
) (
   input logic clk,
   input logic rst,
   rf_multiport_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              busy [DEPTH];
   logic              whit [DEPTH];
   logic [DATA_W-1:0] wsel [DEPTH];
   genvar i, p;
   for (i = 0; i < DEPTH; i++) begin : g_ent
      if (i == RF_ZERO_REG) begin : g_zero
         assign whit[i] = 1'b0;
         assign wsel[i] = '0;
      end else begin : g_wr
         rf_wr_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sel (
            .we(bus.we), .waddr(bus.waddr), .wdata(bus.wdata),
            .addr(ADDR_W'(i)), .hit(whit[i]), .data(wsel[i]));
      end
      // a new issue supersedes a completing write to the same entry
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            mem[i] <= '0;
            busy[i] <= 1'b0;
         end else begin
            if (whit[i]) mem[i] <= wsel[i];
            busy[i] <= (i != RF_ZERO_REG && bus.issue_valid && bus.issue_rd == ADDR_W'(i))
                       || (busy[i] && !whit[i]);
         end
   end
   for (p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              rd_ok;
      assign ra = bus.raddr[p*ADDR_W +: ADDR_W];
      assign rd_ok = !rst && ra != ADDR_W'(RF_ZERO_REG);
`ifdef RF_BYPASS_EN
      logic              bhit;
      logic [DATA_W-1:0] bdata;
      rf_wr_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_byp (
         .we(bus.we), .waddr(bus.waddr), .wdata(bus.wdata),
         .addr(ra), .hit(bhit), .data(bdata));
      assign bus.rdata[p*DATA_W +: DATA_W] = !rd_ok ? '0 : bhit ? bdata : mem[ra];
      assign bus.rbusy[p] = rd_ok && !bhit && busy[ra];
`else
      assign bus.rdata[p*DATA_W +: DATA_W] = rd_ok ? mem[ra] : '0;
      assign bus.rbusy[p] = rd_ok && busy[ra];
`endif
   end
   assign bus.dbg_data = (rst || bus.dbg_sel == ADDR_W'(RF_ZERO_REG)) ? '0 : mem[bus.dbg_sel];
endmodule

// File: tb/tb_rf_multiport_sb.sv
// tb_rf_multiport_sb: directed scoreboard bench for the default and a 64/6/3/3 register file.
module tb_rf_multiport_sb;
`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct {
      string       name;
      int          kind;
      int          port;
      logic [63:0] exp;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   event chk_ev;
   rf_multiport_sb_if b ();
   rf_multiport_sb_if #(.DATA_W(64), .ADDR_W(6), .NUM_RD(3), .NUM_WR(3)) bb ();
   rf_multiport_sb u_dut (.clk(clk), .rst(rst), .bus(b));
   rf_multiport_sb #(.DATA_W(64), .ADDR_W(6), .NUM_RD(3), .NUM_WR(3)) u_big (.clk(clk), .rst(rst), .bus(bb));
   always #5 clk = ~clk;
   function automatic logic [63:0] act_of(input int kind, input int port);
      case (kind)
         0: return 64'(b.rdata[port*32 +: 32]);
         1: return 64'(b.rbusy[port]);
         2: return 64'(b.dbg_data);
         3: return bb.rdata[port*64 +: 64];
         4: return bb.dbg_data;
         default: return 64'(bb.rbusy[port]);
      endcase
   endfunction
   task automatic expect_v(input string n, input int kind, input int port, input logic [63:0] v);
      exp_t e;
      e.name = n;
      e.kind = kind;
      e.port = port;
      e.exp = v;
      q.push_back(e);
   endtask
   // monitor: drains the queue on each negedge, or on demand between edges
   initial forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
         exp_t e;
         logic [63:0] a;
         e = q.pop_front();
         a = act_of(e.kind, e.port);
         checks++;
         if (a !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      b.we = '0; b.waddr = '0; b.wdata = '0; b.issue_valid = 1'b0; b.issue_rd = '0;
      bb.we = '0; bb.waddr = '0; bb.wdata = '0; bb.issue_valid = 1'b0; bb.issue_rd = '0;
   endtask
   initial begin
      rst = 1'b1;
      idle();
      b.raddr = '0; b.dbg_sel = '0; bb.raddr = '0; bb.dbg_sel = '0;
      step();
      // writes and issues during reset must be ignored and outputs held at zero
      b.we = 2'b01; b.waddr = {5'd0, 5'd5}; b.wdata = {32'h0, 32'h0000FFFF};
      b.issue_valid = 1'b1; b.issue_rd = 5'd5;
      b.raddr = {5'd7, 5'd5}; b.dbg_sel = 5'd5; bb.dbg_sel = 6'd1;
      expect_v("rst_rdata0", 0, 0, 64'h0);
      expect_v("rst_rbusy0", 1, 0, 64'h0);
      expect_v("rst_dbg", 2, 0, 64'h0);
      expect_v("rst_big_dbg", 4, 0, 64'h0);
      step();
      rst = 1'b0;
      idle();
      b.we = 2'b01; b.waddr = {5'd0, 5'd5}; b.wdata = {32'h0, 32'h00001234};
      expect_v("wr5_same_cycle", 0, 0, BYP ? 64'h1234 : 64'h0);
      expect_v("wr5_same_busy", 1, 0, 64'h0);
      step();
      idle();
      expect_v("rd5", 0, 0, 64'h1234);
      expect_v("rd5_busy", 1, 0, 64'h0);
      expect_v("dbg5", 2, 0, 64'h1234);
      b.we = 2'b11; b.waddr = {5'd7, 5'd7}; b.wdata = {32'h5555FFFF, 32'hAAAA0000};
      expect_v("conflict_same", 0, 1, BYP ? 64'h5555FFFF : 64'h0);
      step();
      idle();
      b.we = 2'b11; b.waddr = {5'd0, 5'd0}; b.wdata = {32'h22222222, 32'h11111111};
      b.raddr = {5'd0, 5'd7};
      expect_v("conflict_rd7", 0, 0, 64'h5555FFFF);
      expect_v("x0_bypass", 0, 1, 64'h0);
      step();
      idle();
      b.dbg_sel = 5'd0;
      expect_v("x0_read", 0, 1, 64'h0);
      expect_v("x0_busy", 1, 1, 64'h0);
      expect_v("dbg_x0", 2, 0, 64'h0);
      b.we = 2'b01; b.waddr = {5'd0, 5'd3}; b.wdata = {32'h0, 32'h0BADF00D};
      step();
      idle();
      b.we = 2'b10; b.waddr = {5'd3, 5'd0}; b.wdata = {32'hDEADBEEF, 32'h0};
      b.raddr = {5'd3, 5'd3}; b.dbg_sel = 5'd3;
      expect_v("bypass_p1", 0, 1, BYP ? 64'hDEADBEEF : 64'h0BADF00D);
      expect_v("dbg_no_bypass", 2, 0, 64'h0BADF00D);
      step();
      idle();
      expect_v("rd3_after", 0, 1, 64'hDEADBEEF);
      b.issue_valid = 1'b1; b.issue_rd = 5'd9; b.raddr = {5'd3, 5'd9};
      expect_v("issue9_old", 1, 0, 64'h0);
      step();
      idle();
      expect_v("busy9_n1", 1, 0, 64'h1);
      step();
      idle();
      expect_v("busy9_n2", 1, 0, 64'h1);
      b.we = 2'b10; b.waddr = {5'd9, 5'd0}; b.wdata = {32'h00000099, 32'h0};
      expect_v("wb9_busy", 1, 0, BYP ? 64'h0 : 64'h1);
      expect_v("wb9_data", 0, 0, BYP ? 64'h99 : 64'h0);
      step();
      idle();
      expect_v("busy9_clr", 1, 0, 64'h0);
      expect_v("rd9", 0, 0, 64'h99);
      b.we = 2'b01; b.waddr = {5'd0, 5'd9}; b.wdata = {32'h0, 32'h000000AB};
      b.issue_valid = 1'b1; b.issue_rd = 5'd9;
      expect_v("iss_wr9_data", 0, 0, BYP ? 64'hAB : 64'h99);
      step();
      idle();
      expect_v("set_wins", 1, 0, 64'h1);
      expect_v("rd9_ab", 0, 0, 64'hAB);
      b.we = 2'b01; b.waddr = {5'd0, 5'd4}; b.wdata = {32'h0, 32'h00000077};
      b.issue_valid = 1'b1; b.issue_rd = 5'd4;
      step();
      idle();
      b.raddr = {5'd9, 5'd4}; b.dbg_sel = 5'd4;
      expect_v("rd4_pre", 0, 0, 64'h77);
      expect_v("busy4_pre", 1, 0, 64'h1);
      expect_v("dbg4_pre", 2, 0, 64'h77);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      expect_v("async_rdata", 0, 0, 64'h0);
      expect_v("async_rbusy", 1, 0, 64'h0);
      expect_v("async_busy9", 1, 1, 64'h0);
      expect_v("async_dbg", 2, 0, 64'h0);
      -> chk_ev;
      step();
      rst = 1'b0;
      step();
      expect_v("post_rst_rd4", 0, 0, 64'h0);
      expect_v("post_rst_busy4", 1, 0, 64'h0);
      bb.we = 3'b101;
      bb.waddr = {6'd63, 6'd0, 6'd63};
      bb.wdata = {64'hFFFF0000FFFF0000, 64'h0, 64'h123456789ABCDEF0};
      step();
      idle();
      bb.raddr = {6'd63, 6'd63, 6'd63}; bb.dbg_sel = 6'd63;
      for (int k = 0; k < 3; k++) begin
         expect_v($sformatf("big_rd%0d", k), 3, k, 64'hFFFF0000FFFF0000);
         expect_v($sformatf("big_busy%0d", k), 5, k, 64'h0);
      end
      expect_v("big_dbg", 4, 0, 64'hFFFF0000FFFF0000);
      step();
      step();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
